// File: rtl/fixed_dot_product_loader.sv
// Collects eight Q16.16 element pairs into lane registers for a dot-product datapath,
// waits out the datapath latency, then presents the captured result with a valid/ready handshake.
module fixed_dot_product_loader #(
  parameter int LATENCY = 2,
  parameter int LANES   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_in_valid,
  output logic        io_in_ready,
  input  logic [31:0] io_in_a,
  input  logic [31:0] io_in_b,
  output logic [31:0] io_a_0,
  output logic [31:0] io_a_1,
  output logic [31:0] io_a_2,
  output logic [31:0] io_a_3,
  output logic [31:0] io_a_4,
  output logic [31:0] io_a_5,
  output logic [31:0] io_a_6,
  output logic [31:0] io_a_7,
  output logic [31:0] io_b_0,
  output logic [31:0] io_b_1,
  output logic [31:0] io_b_2,
  output logic [31:0] io_b_3,
  output logic [31:0] io_b_4,
  output logic [31:0] io_b_5,
  output logic [31:0] io_b_6,
  output logic [31:0] io_b_7,
  input  logic [31:0] io_dot_c,
  output logic        io_out_valid,
  input  logic        io_out_ready,
  output logic [31:0] io_out_bits
);

  localparam int CW = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);

  typedef enum logic [1:0] {LOAD, WAIT, OUT} state_t;

  state_t                  state, state_nxt;
  logic [2:0]              idx;
  logic [CW-1:0]           wcnt;
  logic [LANES-1:0][31:0]  lane_a, lane_b;
  logic [31:0]             out_bits;
  logic                    accept, wait_done;

  assign accept    = io_in_valid & io_in_ready;
  assign wait_done = (wcnt == CW'(LATENCY));

  always_comb begin
    state_nxt    = state;
    io_in_ready  = 1'b0;
    io_out_valid = 1'b0;
    case (state)
      LOAD: begin
        io_in_ready = 1'b1;
        if (io_in_valid && idx == 3'd7) state_nxt = WAIT;
      end
      WAIT: if (wait_done) state_nxt = OUT;
      OUT: begin
        io_out_valid = 1'b1;
        if (io_out_ready) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  // idx wraps to 0 on the eighth accept, so OUT->LOAD needs no extra clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= LOAD;
      idx      <= '0;
      wcnt     <= '0;
      lane_a   <= '0;
      lane_b   <= '0;
      out_bits <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        lane_a[idx] <= io_in_a;
        lane_b[idx] <= io_in_b;
        idx         <= idx + 3'd1;
      end
      if (state == WAIT) begin
        wcnt <= wait_done ? '0 : wcnt + CW'(1);
        if (wait_done) out_bits <= io_dot_c;
      end
    end
  end

  assign io_out_bits = out_bits;

  assign io_a_0 = lane_a[0];
  assign io_a_1 = lane_a[1];
  assign io_a_2 = lane_a[2];
  assign io_a_3 = lane_a[3];
  assign io_a_4 = lane_a[4];
  assign io_a_5 = lane_a[5];
  assign io_a_6 = lane_a[6];
  assign io_a_7 = lane_a[7];
  assign io_b_0 = lane_b[0];
  assign io_b_1 = lane_b[1];
  assign io_b_2 = lane_b[2];
  assign io_b_3 = lane_b[3];
  assign io_b_4 = lane_b[4];
  assign io_b_5 = lane_b[5];
  assign io_b_6 = lane_b[6];
  assign io_b_7 = lane_b[7];

endmodule

// File: tb/tb_fixed_dot_product_loader.sv
// Bench for fixed_dot_product_loader: a 2-stage Q16.16 dot-product datapath model closes the loop,
// expected results come from plain arithmetic over the pairs the bench sent.
module tb_fixed_dot_product_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        io_in_valid = 1'b0;
  logic        io_out_ready = 1'b0;
  logic [31:0] io_in_a = '0, io_in_b = '0;
  logic [31:0] io_dot_c = '0;
  logic        io_in_ready, io_out_valid;
  logic [31:0] io_out_bits;
  logic [31:0] la[8], lb[8];

  int checks = 0;
  int failures = 0;

  logic [31:0] va[8], vb[8], va2[8], vb2[8];

  always #5 clk = ~clk;

  fixed_dot_product_loader #(.LATENCY(2), .LANES(8)) dut (
    .clk(clk), .reset(reset),
    .io_in_valid(io_in_valid), .io_in_ready(io_in_ready),
    .io_in_a(io_in_a), .io_in_b(io_in_b),
    .io_a_0(la[0]), .io_a_1(la[1]), .io_a_2(la[2]), .io_a_3(la[3]),
    .io_a_4(la[4]), .io_a_5(la[5]), .io_a_6(la[6]), .io_a_7(la[7]),
    .io_b_0(lb[0]), .io_b_1(lb[1]), .io_b_2(lb[2]), .io_b_3(lb[3]),
    .io_b_4(lb[4]), .io_b_5(lb[5]), .io_b_6(lb[6]), .io_b_7(lb[7]),
    .io_dot_c(io_dot_c),
    .io_out_valid(io_out_valid), .io_out_ready(io_out_ready),
    .io_out_bits(io_out_bits)
  );

  // Q16.16 dot product: each full product truncated back to Q16.16, summed, wrapped to 32 bits.
  function automatic logic [31:0] q16_dot(input logic [31:0] a[8], input logic [31:0] b[8]);
    longint s = 0;
    for (int k = 0; k < 8; k++)
      s += (longint'($signed(a[k])) * longint'($signed(b[k]))) >>> 16;
    return s[31:0];
  endfunction

  // Downstream datapath: input register stage then accumulator register stage.
  logic [31:0] dp_a[8], dp_b[8];
  always @(posedge clk) begin
    dp_a     <= la;
    dp_b     <= lb;
    io_dot_c <= q16_dot(dp_a, dp_b);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_lanes(input string tag, input logic [31:0] ea[8], input logic [31:0] eb[8]);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("%s_a%0d", tag, k), la[k], ea[k]);
      chk($sformatf("%s_b%0d", tag, k), lb[k], eb[k]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one pair after an optional idle gap; returns just after the accepting edge.
  task automatic push(input logic [31:0] a, input logic [31:0] b, input int gap, input bit hold);
    int t = 0;
    io_in_valid = 1'b0;
    repeat (gap) step();
    io_in_valid = 1'b1;
    io_in_a = a;
    io_in_b = b;
    while (!io_in_ready && t < 40) begin
      step();
      t++;
    end
    chk("push_ready", 32'(io_in_ready), 32'd1);
    step();
    if (!hold) io_in_valid = 1'b0;
  endtask

  task automatic load_vec(input int maxgap, input bit hold);
    for (int n = 0; n < 8; n++)
      push(va[n], vb[n], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0, hold);
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!io_out_valid && cyc < 20) begin
      step();
      cyc++;
    end
  endtask

  logic [31:0] zero8[8];
  logic [31:0] expv;
  int cyc;

  initial begin
    for (int k = 0; k < 8; k++) zero8[k] = '0;

    // reset state
    step();
    step();
    chk("rst_out_valid", 32'(io_out_valid), 32'd0);
    chk("rst_out_bits", io_out_bits, 32'h0);
    chk_lanes("rst", zero8, zero8);
    reset = 1'b0;
    step();
    chk("rst_in_ready", 32'(io_in_ready), 32'd1);

    // unit A times ramp B, continuous valid, consumer always ready
    io_out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      va[k] = 32'h0001_0000;
      vb[k] = 32'(k) << 16;
    end
    load_vec(0, 0);
    chk_lanes("ramp", va, vb);
    wait_out(cyc);
    chk("ramp_latency", 32'(cyc), 32'd3);
    chk("ramp_result", io_out_bits, 32'h001C_0000);
    chk("ramp_model", io_out_bits, q16_dot(va, vb));
    step();
    chk("ramp_pulse", 32'(io_out_valid), 32'd0);
    chk("ramp_in_ready", 32'(io_in_ready), 32'd1);

    // negative operands
    for (int k = 0; k < 8; k++) begin
      va[k] = 32'hFFFF_0000;
      vb[k] = 32'h0002_0000;
    end
    load_vec(0, 0);
    wait_out(cyc);
    chk("neg_latency", 32'(cyc), 32'd3);
    chk("neg_result", io_out_bits, 32'hFFF0_0000);
    step();

    // random data, random input gaps, consumer stalls 10 cycles
    io_out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      va[k] = $urandom();
      vb[k] = $urandom();
    end
    load_vec(3, 0);
    wait_out(cyc);
    chk("stall_latency", 32'(cyc), 32'd3);
    expv = q16_dot(va, vb);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("stall_valid%0d", i), 32'(io_out_valid), 32'd1);
      chk($sformatf("stall_bits%0d", i), io_out_bits, expv);
      chk($sformatf("stall_in_ready%0d", i), 32'(io_in_ready), 32'd0);
      chk_lanes($sformatf("stall%0d", i), va, vb);
      step();
    end
    io_out_ready = 1'b1;
    step();
    chk("stall_release", 32'(io_out_valid), 32'd0);

    // reset mid-vector, with a handshake offered on the reset edge
    for (int n = 0; n < 5; n++) push($urandom(), $urandom(), 0, 0);
    reset = 1'b1;
    io_in_valid = 1'b1;
    io_in_a = $urandom();
    io_in_b = $urandom();
    step();
    reset = 1'b0;
    io_in_valid = 1'b0;
    chk_lanes("midrst", zero8, zero8);
    chk("midrst_out_valid", 32'(io_out_valid), 32'd0);
    chk("midrst_out_bits", io_out_bits, 32'h0);
    step();
    chk("midrst_in_ready", 32'(io_in_ready), 32'd1);
    for (int k = 0; k < 8; k++) begin
      va[k] = 32'h0001_0000;
      vb[k] = 32'h0001_0000;
    end
    load_vec(1, 0);
    chk_lanes("postrst", va, vb);
    wait_out(cyc);
    chk("postrst_result", io_out_bits, 32'h0008_0000);
    step();

    // back-to-back vectors with valid held high through WAIT/OUT
    for (int k = 0; k < 8; k++) begin
      va[k] = $urandom();
      vb[k] = $urandom();
      va2[k] = $urandom();
      vb2[k] = $urandom();
    end
    va2[0] = ~va[0];
    load_vec(0, 1);
    io_in_a = va2[0];
    io_in_b = vb2[0];
    cyc = 0;
    while (!io_out_valid && cyc < 20) begin
      chk($sformatf("b2b_wait_a0_%0d", cyc), la[0], va[0]);
      chk($sformatf("b2b_wait_a7_%0d", cyc), la[7], va[7]);
      step();
      cyc++;
    end
    chk("b2b_latency", 32'(cyc), 32'd3);
    chk("b2b_result1", io_out_bits, q16_dot(va, vb));
    chk_lanes("b2b_out", va, vb);
    step();
    chk("b2b_in_ready", 32'(io_in_ready), 32'd1);
    chk("b2b_a0_kept", la[0], va[0]);
    step();
    chk("b2b_a0_new", la[0], va2[0]);
    chk("b2b_b0_new", lb[0], vb2[0]);
    io_in_valid = 1'b0;
    for (int n = 1; n < 8; n++) push(va2[n], vb2[n], 0, 0);
    chk_lanes("b2b_vec2", va2, vb2);
    wait_out(cyc);
    chk("b2b_latency2", 32'(cyc), 32'd3);
    chk("b2b_result2", io_out_bits, q16_dot(va2, vb2));
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fixed_dot_product_loader.md
FIXED_DOT_PRODUCT_LOADER -- requirements
Module: fixed_dot_product_loader

Interface
REQ-001 SHALL have parameter: LATENCY, 2, cycles from lane outputs stable to downstream io_dot_c valid (input regs + accumulator reg).
REQ-002 SHALL have parameter: LANES, 8, elements per vector (fixed at 8; other values unsupported).
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 SHALL have port: clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port: reset  input  1  synchronous active-high reset.
REQ-006 SHALL have port: io_in_valid  input  1  element pair offered.
REQ-007 SHALL have port: io_in_ready  output  1  element pair accepted when valid&ready.
REQ-008 SHALL have port: io_in_a  input  32  operand-A element, Q16.16 two's complement.
REQ-009 SHALL have port: io_in_b  input  32  operand-B element, Q16.16 two's complement.
REQ-010 SHALL have ports: io_a_0..io_a_7  output  32 each  assembled A lanes to dot-product datapath.
REQ-011 SHALL have ports: io_b_0..io_b_7  output  32 each  assembled B lanes to dot-product datapath.
REQ-012 SHALL have port: io_dot_c  input  32  Q16.16 result from dot-product datapath.
REQ-013 SHALL have port: io_out_valid  output  1  result available.
REQ-014 SHALL have port: io_out_ready  input  1  consumer takes result when valid&ready.
REQ-015 SHALL have port: io_out_bits  output  32  captured Q16.16 dot product.

Function
REQ-016 SHALL implement FSM states LOAD, WAIT, OUT; io_in_ready = 1 only in LOAD, io_out_valid = 1 only in OUT.
REQ-017 SHALL, in LOAD, write accepted pair n (n = 0..7, 3-bit index counter) into io_a_n/io_b_n at the accept edge; first pair after entering LOAD goes to lane 0.
REQ-018 SHALL hold index and lanes unchanged in LOAD cycles without handshake (no timeout, gaps of any length legal).
REQ-019 SHALL, on accepting pair 7, wrap index to 0 and enter WAIT at the same edge.
REQ-020 SHALL hold all 16 lane outputs constant from the edge accepting pair 7 until leaving WAIT.
REQ-021 SHALL remain in WAIT for exactly LATENCY+1 cycles (wait counter 0..LATENCY); at the edge ending the cycle with counter == LATENCY, capture io_dot_c into io_out_bits and enter OUT.
REQ-022 SHALL yield io_out_valid asserted LATENCY+1 cycles after the edge accepting pair 7 (3 cycles at default).
REQ-023 SHALL pass io_dot_c to io_out_bits unmodified (no rounding, saturation, or shift); ignore io_dot_c outside the capture edge.
REQ-024 SHALL, in OUT, hold io_out_valid and io_out_bits stable until io_out_ready; on valid&ready edge enter LOAD with index 0.
REQ-025 SHALL keep io_in_ready = 0 during OUT even if io_out_ready = 1 (no overlap; earliest next accept is the cycle after the output handshake).
REQ-026 SHALL keep previous lane values visible in LOAD until overwritten lane by lane (no clear between vectors).
REQ-027 SHALL ignore io_in_valid outside LOAD (no pair consumed, no lane change).

Reset
REQ-028 SHALL, on reset high at any rising edge in any state, enter LOAD, set index and wait counter to 0, all lanes to 0x00000000, io_out_bits to 0x00000000, io_out_valid to 0, io_in_ready to 1 the cycle after reset deasserts.
REQ-029 SHALL discard partially loaded vectors and pending results when reset occurs mid-operation; reset takes priority over any simultaneous handshake.

Verification (bench connects the team's 8-lane Q16.16 dot-product datapath with LATENCY=2)
REQ-030 SHALL pass: A all 0x00010000, B lane k = k*0x00010000, continuous valid, out_ready=1 -> io_out_bits 0x001C0000 (28.0), out_valid 3 cycles after 8th accept, one cycle wide.
REQ-031 SHALL pass: A all 0xFFFF0000 (-1.0), B all 0x00020000 (2.0) -> io_out_bits 0xFFF00000 (-16.0).
REQ-032 SHALL pass: random valid gaps on input and out_ready held low 10 cycles -> correct result held stable all 10 cycles, in_ready 0 throughout, lanes unchanged.
REQ-033 SHALL pass: reset asserted after 5 accepts -> all lanes 0, index 0; next 8 pairs (A=B=0x00010000) -> 0x00080000.
REQ-034 SHALL pass: io_in_valid held high during WAIT/OUT -> no extra lane writes; two back-to-back vectors produce two correct results, second vector's first accept exactly one cycle after first output handshake.
